// File: rtl/pc_pkg.sv
// Constants shared by the control FSM and the program-counter unit, so both sides
// agree on next-PC source encodings and on the FSM state in which PC is written.
package pc_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_REL  = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;
  localparam logic [1:0] PCSRC_TRAP = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100
  } state_e;

  localparam logic [2:0] ST_UPDATE = ST_WB;

  function automatic logic src_needs_align(input logic [1:0] src);
    return (src == PCSRC_REL) || (src == PCSRC_JALR);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between the multicycle control/datapath (master) and the PC unit (slave).
interface pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12,
  parameter int CNT_W = 32
);

  logic [2:0]       estado;
  logic             stall;
  logic [1:0]       pcsrc;
  logic [IMM_W-1:0] immediate;
  logic [XLEN-1:0]  rs1_val;

  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  pc_old;
  logic [XLEN-1:0]  pc_plus;
  logic             misaligned;
  logic [CNT_W-1:0] instret;

  modport master (
    output estado, stall, pcsrc, immediate, rs1_val,
    input  PC, pc_old, pc_plus, misaligned, instret
  );

  modport slave (
    input  estado, stall, pcsrc, immediate, rs1_val,
    output PC, pc_old, pc_plus, misaligned, instret
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation: immediate extension, the three adders,
// source selection, JALR bit0 handling and misaligned-target redirect to the trap vector.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              IMM_W     = 12,
  parameter int              IMM_SHIFT = 0,
  parameter int              INC       = 1,
  parameter logic [XLEN-1:0] TRAP_VEC  = '0
) (
  input  logic [XLEN-1:0]  pc_i,
  input  logic [1:0]       pcsrc_i,
  input  logic [IMM_W-1:0] immediate_i,
  input  logic [XLEN-1:0]  rs1_val_i,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  pc_plus_o,
  output logic             misaligned_o
);

  // Byte-addressed builds enforce word alignment and clear JALR bit0;
  // word-addressed builds take every target as-is.
  localparam bit              CHECK_ALIGN = (INC == 4);
  localparam logic [XLEN-1:0] JALR_MASK   = CHECK_ALIGN ? ~XLEN'(1) : '1;

  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] seq_sum;
  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] raw_tgt;

  assign imm_sx   = XLEN'($signed(immediate_i));
  assign imm_x    = imm_sx << IMM_SHIFT;

  assign seq_sum  = pc_i + XLEN'(INC);
  assign rel_sum  = pc_i + imm_x;
  assign jalr_sum = rs1_val_i + imm_x;
  assign jalr_tgt = jalr_sum & JALR_MASK;

  always_comb begin
    raw_tgt = seq_sum;
    case (pcsrc_i)
      PCSRC_SEQ:  raw_tgt = seq_sum;
      PCSRC_REL:  raw_tgt = rel_sum;
      PCSRC_JALR: raw_tgt = jalr_tgt;
      default:    raw_tgt = TRAP_VEC;
    endcase
  end

  assign misaligned_o = CHECK_ALIGN && src_needs_align(pcsrc_i) && (raw_tgt[1:0] != 2'b00);
  assign target_o     = misaligned_o ? TRAP_VEC : raw_tgt;
  assign pc_plus_o    = seq_sum;

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit for the multicycle RISC-V datapath: PC, previous PC,
// misaligned pulse and retired-instruction counter, written once per update cycle.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              IMM_W        = 12,
  parameter int              IMM_SHIFT    = 0,
  parameter int              INC          = 1,
  parameter logic [XLEN-1:0] RESET_VEC    = '0,
  parameter logic [XLEN-1:0] TRAP_VEC     = '0,
  parameter logic [2:0]      UPDATE_STATE = ST_UPDATE,
  parameter int              CNT_W        = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_old_q, pc_old_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mis_q, mis_d;

  logic [XLEN-1:0]  target;
  logic             target_mis;
  logic             upd;

  pc_target_calc #(
    .XLEN      (XLEN),
    .IMM_W     (IMM_W),
    .IMM_SHIFT (IMM_SHIFT),
    .INC       (INC),
    .TRAP_VEC  (TRAP_VEC)
  ) u_calc (
    .pc_i         (pc_q),
    .pcsrc_i      (bus.pcsrc),
    .immediate_i  (bus.immediate),
    .rs1_val_i    (bus.rs1_val),
    .target_o     (target),
    .pc_plus_o    (bus.pc_plus),
    .misaligned_o (target_mis)
  );

  // Stall wins over the FSM state; a held UPDATE_STATE advances PC every cycle.
  assign upd = rst_n && (bus.estado == UPDATE_STATE) && !bus.stall;

  always_comb begin
    pc_d      = pc_q;
    pc_old_d  = pc_old_q;
    instret_d = instret_q;
    mis_d     = 1'b0;
    if (upd) begin
      pc_d      = target;
      pc_old_d  = pc_q;
      instret_d = instret_q + CNT_W'(1);
      mis_d     = target_mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      pc_old_q  <= RESET_VEC;
      instret_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_old_q  <= pc_old_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.pc_old     = pc_old_q;
  assign bus.instret    = instret_q;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Three pc_gen builds (byte-addressed, byte-addressed with shifted imm, word-addressed with
// a 4-bit counter) share one stimulus stream and are checked against an arithmetic model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  estado = 3'd0;
  logic        stall = 1'b0;
  logic [1:0]  pcsrc = 2'd0;
  logic [11:0] imm = 12'd0;
  logic [31:0] rs1 = 32'd0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32), .IMM_W(12), .CNT_W(32)) i0 ();
  pc_gen_if #(.XLEN(32), .IMM_W(12), .CNT_W(32)) i1 ();
  pc_gen_if #(.XLEN(32), .IMM_W(12), .CNT_W(4))  i2 ();

  assign i0.estado = estado;  assign i0.stall = stall;  assign i0.pcsrc = pcsrc;
  assign i0.immediate = imm;  assign i0.rs1_val = rs1;
  assign i1.estado = estado;  assign i1.stall = stall;  assign i1.pcsrc = pcsrc;
  assign i1.immediate = imm;  assign i1.rs1_val = rs1;
  assign i2.estado = estado;  assign i2.stall = stall;  assign i2.pcsrc = pcsrc;
  assign i2.immediate = imm;  assign i2.rs1_val = rs1;

  pc_gen #(.XLEN(32), .IMM_W(12), .IMM_SHIFT(0), .INC(4), .RESET_VEC(32'h100),
           .TRAP_VEC(32'h80), .UPDATE_STATE(3'b100), .CNT_W(32))
    u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  pc_gen #(.XLEN(32), .IMM_W(12), .IMM_SHIFT(1), .INC(4), .RESET_VEC(32'h100),
           .TRAP_VEC(32'h80), .UPDATE_STATE(3'b100), .CNT_W(32))
    u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  pc_gen #(.XLEN(32), .IMM_W(12), .IMM_SHIFT(0), .INC(1), .RESET_VEC(32'h100),
           .TRAP_VEC(32'h40), .UPDATE_STATE(3'b100), .CNT_W(4))
    u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  // Reference model: build parameters and architectural state per instance.
  int    p_inc [3] = '{4, 4, 1};
  int    p_sh  [3] = '{0, 1, 0};
  int    p_cw  [3] = '{32, 32, 4};
  longint p_rv [3] = '{64'h100, 64'h100, 64'h100};
  longint p_tv [3] = '{64'h80, 64'h80, 64'h40};

  longint m_pc  [3];
  longint m_old [3];
  longint m_cnt [3];
  bit     m_mis [3];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  localparam longint MASK32 = 64'hFFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pc[k]  = p_rv[k];
      m_old[k] = p_rv[k];
      m_cnt[k] = 0;
      m_mis[k] = 1'b0;
    end
  endtask

  // Applies the next-PC rules for one clock edge with the current stimulus.
  task automatic model_edge();
    longint immx, t;
    bit     mis;
    for (int k = 0; k < 3; k++) begin
      if (estado == 3'd4 && !stall) begin
        immx = longint'($signed(imm)) * (longint'(1) << p_sh[k]);
        mis  = 1'b0;
        case (pcsrc)
          2'd0: t = (m_pc[k] + p_inc[k]) & MASK32;
          2'd1: t = (m_pc[k] + immx) & MASK32;
          2'd2: begin
            t = (longint'(rs1) + immx) & MASK32;
            if (p_inc[k] == 4 && (t % 2) == 1) t = t - 1;
          end
          default: t = p_tv[k];
        endcase
        if (p_inc[k] == 4 && (pcsrc == 2'd1 || pcsrc == 2'd2) && (t % 4) != 0) begin
          t   = p_tv[k];
          mis = 1'b1;
        end
        m_old[k] = m_pc[k];
        m_pc[k]  = t;
        m_cnt[k] = (m_cnt[k] + 1) & ((longint'(1) << p_cw[k]) - 1);
        m_mis[k] = mis;
      end else begin
        m_mis[k] = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int k, input string tag, input logic [31:0] pc,
                           input logic [31:0] old, input logic [31:0] plus,
                           input logic mis, input logic [31:0] cnt);
    check($sformatf("%s.u%0d.pc", tag, k), 64'(pc), m_pc[k]);
    check($sformatf("%s.u%0d.pc_old", tag, k), 64'(old), m_old[k]);
    check($sformatf("%s.u%0d.pc_plus", tag, k), 64'(plus), (m_pc[k] + p_inc[k]) & MASK32);
    check($sformatf("%s.u%0d.misaligned", tag, k), 64'(mis), 64'(m_mis[k]));
    check($sformatf("%s.u%0d.instret", tag, k), 64'(cnt), m_cnt[k]);
  endtask

  task automatic check_all(input string tag);
    check_dut(0, tag, i0.PC, i0.pc_old, i0.pc_plus, i0.misaligned, i0.instret);
    check_dut(1, tag, i1.PC, i1.pc_old, i1.pc_plus, i1.misaligned, i1.instret);
    check_dut(2, tag, i2.PC, i2.pc_old, i2.pc_plus, i2.misaligned, 32'(i2.instret));
  endtask

  task automatic step(input string tag, input logic [2:0] e, input logic s,
                      input logic [1:0] src, input logic [11:0] im, input logic [31:0] r);
    estado = e; stall = s; pcsrc = src; imm = im; rs1 = r;
    #1;
    check($sformatf("%s.u0.pc_plus_comb", tag), 64'(i0.pc_plus), (m_pc[0] + 4) & MASK32);
    check($sformatf("%s.u2.pc_plus_comb", tag), 64'(i2.pc_plus), (m_pc[2] + 1) & MASK32);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    n_txn++;
    $display("txn %0d %s e=%0d s=%0b src=%0d imm=%03h rs1=%08h pc=%08h/%08h/%08h cnt=%0d/%0d/%0d",
             n_txn, tag, e, s, src, im, r, i0.PC, i1.PC, i2.PC, i0.instret, i1.instret, i2.instret);
  endtask

  // Asserts reset between clock edges and checks that it takes effect without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    check({tag, ".u0.pc_const"}, 64'(i0.PC), 64'h100);
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    rst_n = 1'b1;
    $display("txn reset %s pc=%08h/%08h/%08h", tag, i0.PC, i1.PC, i2.PC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  e;
    logic        s;
    logic [1:0]  src;
    logic [11:0] im;
    logic [31:0] r;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("init");

    // Sequential update, then a non-update state leaves everything unchanged.
    step("seq", 3'd4, 1'b0, 2'd0, 12'h000, 32'h0);
    check("seq.u0.pc_const", 64'(i0.PC), 64'h104);
    check("seq.u0.old_const", 64'(i0.pc_old), 64'h100);
    check("seq.u0.cnt_const", 64'(i0.instret), 64'd1);
    step("idle", 3'd3, 1'b0, 2'd0, 12'h000, 32'h0);
    check("idle.u0.pc_const", 64'(i0.PC), 64'h104);

    // Negative relative branch with shifted immediate.
    step("set200", 3'd4, 1'b0, 2'd2, 12'h000, 32'h200);
    step("relneg", 3'd4, 1'b0, 2'd1, 12'hFFC, 32'h0);
    check("relneg.u1.pc_const", 64'(i1.PC), 64'h1F8);

    // Wrap at the top of the address space.
    step("setmax", 3'd4, 1'b0, 2'd2, 12'h000, 32'hFFFF_FFFC);
    step("wrap", 3'd4, 1'b0, 2'd0, 12'h000, 32'h0);
    check("wrap.u0.pc_const", 64'(i0.PC), 64'h0);

    // JALR: bit0 cleared, still misaligned, redirected to trap with a one-cycle flag.
    step("jalrmis", 3'd4, 1'b0, 2'd2, 12'h002, 32'h1001);
    check("jalrmis.u0.pc_const", 64'(i0.PC), 64'h80);
    check("jalrmis.u0.mis_const", 64'(i0.misaligned), 64'd1);
    step("misdrop", 3'd0, 1'b0, 2'd0, 12'h000, 32'h0);
    check("misdrop.u0.mis_const", 64'(i0.misaligned), 64'd0);

    // Stall holds everything for three cycles in the update state.
    for (int i = 0; i < 3; i++) step("stall", 3'd4, 1'b1, 2'd0, 12'h000, 32'h0);
    check("stall.u0.pc_const", 64'(i0.PC), 64'h80);
    step("unstall", 3'd4, 1'b0, 2'd0, 12'h000, 32'h0);
    check("unstall.u0.pc_const", 64'(i0.PC), 64'h84);

    // Word-addressed build: odd targets allowed, trap still counts.
    step("set5", 3'd4, 1'b0, 2'd2, 12'h000, 32'h5);
    step("rel3", 3'd4, 1'b0, 2'd1, 12'h003, 32'h0);
    check("rel3.u2.pc_const", 64'(i2.PC), 64'h8);
    check("rel3.u2.mis_const", 64'(i2.misaligned), 64'd0);
    step("trap", 3'd4, 1'b0, 2'd3, 12'h000, 32'h0);
    check("trap.u2.pc_const", 64'(i2.PC), 64'h40);

    async_reset("rst1");

    // Random traffic, biased toward the update state, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      e   = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      s   = ($urandom_range(0, 3) == 0);
      src = 2'($urandom_range(0, 3));
      im  = 12'($urandom);
      r   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        im = im & 12'hFFC;
        r  = r & 32'hFFFF_FFFC;
      end
      step("rnd", e, s, src, im, r);
      if (i == 200) async_reset("rst2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
